// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared definitions for the bus cycle controller.
// Contents: one-hot bus state enum, chip-select bit positions, I/O decode
// constants and the read value returned for unmapped addresses.
package bus_cycle_ctrl_pkg;

  // One-hot cycle states; IDLE between cycles, T1..T4 for one bus cycle
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    T1   = 5'b00010,
    T2   = 5'b00100,
    T3   = 5'b01000,
    T4   = 5'b10000
  } bus_state_e;

  // Bit positions inside the active-low chip-select vector
  localparam logic [1:0] CS_MEM_UPPER = 2'd0;
  localparam logic [1:0] CS_MEM_LOWER = 2'd1;
  localparam logic [1:0] CS_IO_FF     = 2'd2;
  localparam logic [1:0] CS_IO_1C     = 2'd3;

  // I/O decode: page FFxx, and the 1Kbyte block starting at 1C00
  localparam logic [7:0] IO_FF_PAGE  = 8'hFF;
  localparam logic [5:0] IO_1C_BLOCK = 6'b000111;

  // Read data reported when nothing answers the address
  localparam logic [7:0] RDATA_UNMAPPED = 8'hFF;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder for the bus cycle controller.
// Ports:
//   mio      in   1 = memory space, 0 = I/O space
//   addr     in   20-bit cycle address
//   cs_n     out  active-low chip selects (one bit low, or all high)
//   unmapped out  high when no device claims the address
module bus_addr_decode
  import bus_cycle_ctrl_pkg::*;
(
  input  logic        mio,
  input  logic [19:0] addr,
  output logic [3:0]  cs_n,
  output logic        unmapped
);

  // Only A19 (memory) and A15..A8 (I/O) take part in the decode
  logic unusedAddrBits;
  assign unusedAddrBits = ^{addr[18:16], addr[7:0]};

  // Memory space is always claimed by one of the two halves; I/O space has
  // two small windows and everything else is unmapped.
  always_comb begin
    cs_n     = 4'hF;
    unmapped = 1'b0;
    if (mio) begin
      if (addr[19]) cs_n[CS_MEM_UPPER] = 1'b0;
      else          cs_n[CS_MEM_LOWER] = 1'b0;
    end else if (addr[15:8] == IO_FF_PAGE) begin
      cs_n[CS_IO_FF] = 1'b0;
    end else if (addr[15:10] == IO_1C_BLOCK) begin
      cs_n[CS_IO_1C] = 1'b0;
    end else begin
      unmapped = 1'b1;
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Two-requester bus cycle controller running fixed four-state bus cycles
// (T1 address/ALE, T2-T3 strobes, T4 completion) with round-robin arbitration.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req, req_we, req_mio     per-requester request, write flag, memory flag
//   req_addr, req_wdata      per-requester address and write data
//   gnt, done, rdata, err    owner indication, T4 completion pulse, read data,
//                            unmapped-address error
//   Address, Data            device address bus, bidirectional data bus
//   ALE, RD, WR, CS          address latch enable, active-low strobes/selects
module bus_cycle_ctrl
  import bus_cycle_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ-1:0]       req_mio,
  input  logic [NREQ-1:0][19:0] req_addr,
  input  logic [NREQ-1:0][7:0]  req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [7:0]            rdata,
  output logic                  err,
  output logic [19:0]           Address,
  inout  wire  [7:0]            Data,
  output logic                  ALE,
  output logic                  RD,
  output logic                  WR,
  output logic [3:0]            CS
);

  bus_state_e  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        mio_q, mio_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;

  logic [1:0]  ownerMask;
  logic [1:0]  candidates;
  logic        grantIdx;
  logic        startCycle;
  logic        inCycle;
  logic        strobePhase;
  logic [3:0]  decCsN;
  logic        decUnmapped;

  // Decode always works on the latched cycle, never on live request inputs
  bus_addr_decode u_decode (
    .mio      (mio_q),
    .addr     (addr_q),
    .cs_n     (decCsN),
    .unmapped (decUnmapped)
  );

  assign ownerMask   = {owner_q, ~owner_q};
  assign inCycle     = (state_q == T1) || (state_q == T2) ||
                       (state_q == T3) || (state_q == T4);
  assign strobePhase = (state_q == T2) || (state_q == T3);

  // State register and cycle context; reset aborts any cycle in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      mio_q   <= 1'b0;
      addr_q  <= 20'h0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      mio_q   <= mio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic. In T4 the finishing owner is masked out so a requester
  // still holding req for the cycle just completed cannot win again
  // immediately. The pointer favours one requester and afterwards points at
  // the one not just granted.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    mio_d      = mio_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    startCycle = 1'b0;
    candidates = (state_q == T4) ? (req & ~ownerMask) : req;
    grantIdx   = candidates[ptr_q] ? ptr_q : ~ptr_q;

    case (state_q)
      IDLE: begin
        if (|candidates) begin
          state_d    = T1;
          startCycle = 1'b1;
        end
      end
      T1: state_d = T2;
      T2: state_d = T3;
      T3: begin
        state_d = T4;
        if (!we_q) rdata_d = decUnmapped ? RDATA_UNMAPPED : Data;
      end
      T4: begin
        if (|candidates) begin
          state_d    = T1;
          startCycle = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (startCycle) begin
      owner_d = grantIdx;
      ptr_d   = ~grantIdx;
      we_d    = req_we[grantIdx];
      mio_d   = req_mio[grantIdx];
      addr_d  = req_addr[grantIdx];
      wdata_d = req_wdata[grantIdx];
    end
  end

  // Bus outputs decode directly from the state, so reset and illegal state
  // encodings both leave the bus inactive.
  assign gnt     = inCycle ? ownerMask : 2'b00;
  assign done    = (state_q == T4) ? ownerMask : 2'b00;
  assign err     = (state_q == T4) && decUnmapped;
  assign rdata   = rdata_q;
  assign Address = inCycle ? addr_q : 20'h0;
  assign ALE     = (state_q == T1);
  assign RD      = ~(strobePhase & ~we_q);
  assign WR      = ~(strobePhase & we_q);
  assign CS      = ((state_q == T1) || strobePhase) ? decCsN : 4'hF;
  assign Data    = (strobePhase && we_q) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Testbench for bus_cycle_ctrl: table of single-requester bus cycles, plus
// hand-written sequences for reset mid-cycle, back-to-back arbitration and
// request changes during a cycle. A small byte memory acts as the device.
module tb_bus_cycle_ctrl;

  typedef struct {
    logic        reqIdx;
    logic        we;
    logic        mio;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  expCs;
    logic        expErr;
    logic [7:0]  expRdata;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       req_we;
  logic [1:0]       req_mio;
  logic [1:0][19:0] req_addr;
  logic [1:0][7:0]  req_wdata;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [7:0]       rdata;
  logic             err;
  logic [19:0]      Address;
  wire  [7:0]       Data;
  logic             ALE;
  logic             RD;
  logic             WR;
  logic [3:0]       CS;

  int checks;
  int failures;
  int writeCount;
  logic wrLowPrev;
  logic [7:0] mem [0:255];
  logic devOe;

  vec_t vecs [7];

  bus_cycle_ctrl #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_mio   (req_mio),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .Address   (Address),
    .Data      (Data),
    .ALE       (ALE),
    .RD        (RD),
    .WR        (WR),
    .CS        (CS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device: drives the data bus while selected and read-strobed; stores a
  // write at the clock edge that ends the second strobed cycle.
  assign devOe = !RD && (CS != 4'hF);
  assign Data  = devOe ? mem[Address[7:0]] : 8'hzz;

  always @(posedge clk) begin
    if (!WR && wrLowPrev && CS != 4'hF) begin
      mem[Address[7:0]] = Data;
      writeCount = writeCount + 1;
    end
    wrLowPrev = !WR;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_we[v.reqIdx]    = v.we;
    req_mio[v.reqIdx]   = v.mio;
    req_addr[v.reqIdx]  = v.addr;
    req_wdata[v.reqIdx] = v.wdata;
    req[v.reqIdx]       = 1'b1;
  endtask

  // Expected outputs during cycle c (1..4 = T1..T4) of transaction v
  task automatic checkCycle(input string tag, input int c, input vec_t v);
    logic [1:0] own;
    logic strobe;
    own    = v.reqIdx ? 2'b10 : 2'b01;
    strobe = (c == 2) || (c == 3);
    checkOutput($sformatf("%s T%0d gnt", tag, c), gnt, own);
    checkOutput($sformatf("%s T%0d done", tag, c), done, (c == 4) ? own : 2'b00);
    checkOutput($sformatf("%s T%0d err", tag, c), err, (c == 4) && v.expErr);
    checkOutput($sformatf("%s T%0d ALE", tag, c), ALE, c == 1);
    checkOutput($sformatf("%s T%0d CS", tag, c), CS, (c < 4) ? v.expCs : 4'hF);
    checkOutput($sformatf("%s T%0d RD", tag, c), RD, !(strobe && !v.we));
    checkOutput($sformatf("%s T%0d WR", tag, c), WR, !(strobe && v.we));
    checkOutput($sformatf("%s T%0d Address", tag, c), Address, v.addr);
    if (strobe && v.we) checkOutput($sformatf("%s T%0d Data", tag, c), Data, v.wdata);
    if (c == 4) checkOutput($sformatf("%s T4 rdata", tag), rdata, v.expRdata);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " idle gnt"}, gnt, 2'b00);
    checkOutput({tag, " idle ALE"}, ALE, 1'b0);
    checkOutput({tag, " idle CS"}, CS, 4'hF);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " gnt"}, gnt, 2'b00);
    checkOutput({tag, " done"}, done, 2'b00);
    checkOutput({tag, " err"}, err, 1'b0);
    checkOutput({tag, " rdata"}, rdata, 8'h00);
    checkOutput({tag, " ALE"}, ALE, 1'b0);
    checkOutput({tag, " RD"}, RD, 1'b1);
    checkOutput({tag, " WR"}, WR, 1'b1);
    checkOutput({tag, " CS"}, CS, 4'hF);
    checkOutput({tag, " Address"}, Address, 20'h0);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkCycle(tag, c, v);
    end
    req = 2'b00;
    @(negedge clk);
    checkIdle(tag);
  endtask

  initial begin
    vec_t vA, vB, vW;
    int writesBefore;

    checks     = 0;
    failures   = 0;
    writeCount = 0;
    wrLowPrev  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'h77;

    //         idx   we    mio   addr       wdata  expCs    err   rdata
    vecs[0] = '{1'b0, 1'b0, 1'b1, 20'h80010, 8'h00, 4'b1110, 1'b0, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 20'h0FF04, 8'hC3, 4'b1011, 1'b0, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 20'h0FF04, 8'h00, 4'b1011, 1'b0, 8'hC3};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 20'h01234, 8'h00, 4'b1111, 1'b1, 8'hFF};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 20'h00020, 8'h00, 4'b1101, 1'b0, 8'h77};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 20'h01C33, 8'h3C, 4'b0111, 1'b0, 8'h77};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 20'h01C33, 8'h00, 4'b0111, 1'b0, 8'h3C};

    rst       = 1'b1;
    req       = 2'b00;
    req_we    = 2'b00;
    req_mio   = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    #3;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkIdle("noReq");

    for (int i = 0; i < 7; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Reset during T2 of a write: immediate bus release, no done, no write
    vW = '{1'b1, 1'b1, 1'b0, 20'h0FF04, 8'h11, 4'b1011, 1'b0, 8'h3C};
    writesBefore = writeCount;
    applyStimulus(vW);
    @(negedge clk);
    checkCycle("rstWr", 1, vW);
    @(negedge clk);
    checkCycle("rstWr", 2, vW);
    rst = 1'b1;
    req = 2'b00;
    #1;
    checkResetOutputs("rstMidT2");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rstWr after%0d done", i), done, 2'b00);
    end
    checkOutput("rstWr writeCount", writeCount, writesBefore);
    checkOutput("rstWr mem", mem[8'h04], 8'hC3);

    // Both requesting from reset: grants alternate 0,1,0,1 with no idle gap
    vA = '{1'b0, 1'b0, 1'b1, 20'h80010, 8'h00, 4'b1110, 1'b0, 8'h5A};
    vB = '{1'b1, 1'b0, 1'b1, 20'h00020, 8'h00, 4'b1101, 1'b0, 8'h77};
    applyStimulus(vA);
    applyStimulus(vB);
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        checkCycle($sformatf("rr%0d", k), c, (k % 2 == 0) ? vA : vB);
      end
    end
    req = 2'b00;
    @(negedge clk);
    checkIdle("rr");

    // Request address changed in T2 must not disturb the latched cycle
    applyStimulus(vA);
    @(negedge clk);
    checkCycle("addrHold", 1, vA);
    @(negedge clk);
    checkCycle("addrHold", 2, vA);
    req_addr[0] = 20'h00000;
    @(negedge clk);
    checkCycle("addrHold", 3, vA);
    @(negedge clk);
    checkCycle("addrHold", 4, vA);
    req = 2'b00;
    @(negedge clk);
    checkIdle("addrHold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 The block SHALL have one parameter: NREQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 The block SHALL have the following ports (one per line: name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  2  per-requester bus request; held high until the matching done.
- req_we  in  2  per-requester transfer type: 1 = write, 0 = read.
- req_mio  in  2  per-requester space select: 1 = memory, 0 = I/O.
- req_addr  in  2x20  per-requester address.
- req_wdata  in  2x8  per-requester write data.
- gnt  out  2  one-hot; marks the requester owning the current cycle.
- done  out  2  one-cycle pulse in T4 to the owner.
- rdata  out  8  captured read data; valid with done.
- err  out  1  pulses with done when the address is unmapped.
- Address  out  20  device address bus.
- Data  inout  8  device data bus.
- ALE  out  1  address latch enable, active-high.
- RD  out  1  read strobe, active-low.
- WR  out  1  write strobe, active-low.
- CS  out  4  device chip selects, active-low: [0] mem upper, [1] mem lower, [2] io FF00 block, [3] io 1C00 block.

Function
REQ-003 The FSM SHALL use five one-hot states: IDLE, T1, T2, T3, T4.
REQ-004 IDLE -> T1 when any req is high; otherwise the FSM SHALL stay in IDLE.
REQ-005 The FSM SHALL advance T1 -> T2 -> T3 -> T4 unconditionally, one cycle each.
REQ-006 From T4 the FSM SHALL go to T1 if any req, excluding the finishing owner's, is high; otherwise to IDLE.
REQ-007 The finishing owner's req SHALL be ignored in the T4 decision.
REQ-008 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the favoured requester and flips to the other requester after every grant; the pointer is 0 after reset.
REQ-009 Address, type, space and wdata SHALL be latched on entry to T1; later changes to req_* SHALL be ignored until T4.
REQ-010 The selected requester's gnt bit SHALL be high from T1 through T4 inclusive.
REQ-011 Decode, memory space: addr[19]=1 selects CS[0]; addr[19]=0 selects CS[1].
REQ-012 Decode, I/O space: addr[15:8]=8'hFF selects CS[2]; addr[15:10]=6'b000111 selects CS[3]; any other I/O address is unmapped.
REQ-013 For an unmapped address, no CS bit SHALL assert, rdata SHALL be 8'hFF, and err SHALL pulse with done.
REQ-014 The selected CS SHALL be low from T1 through T3 and high in T4 and IDLE.
REQ-015 ALE SHALL be high only in T1.
REQ-016 Address SHALL carry the latched address from T1 through T4.
REQ-017 RD SHALL be low in T2 and T3 of a read cycle and high otherwise.
REQ-018 WR SHALL be low in T2 and T3 of a write cycle and high otherwise.
REQ-019 Data SHALL be driven with the latched wdata in T2 and T3 of a write cycle and be high-impedance at all other times.
REQ-020 Read data SHALL be sampled from Data at the rising edge ending T3, held in rdata until the next read capture, and presented with done in T4.
REQ-021 Latency from req rising in IDLE to done SHALL be 4 cycles (T1..T4).
REQ-022 Back-to-back cycles SHALL need no idle gap (T4 -> T1).
REQ-023 Simultaneous requests SHALL be resolved by the pointer; with a single requester, that requester SHALL be granted regardless of the pointer.
REQ-024 Every valid one-hot state SHALL be covered; any illegal state encoding SHALL return to IDLE on the next clock.

Reset
REQ-025 While rst is high, regardless of clk: state = IDLE, pointer = 0, gnt = 0, done = 0, err = 0, rdata = 8'h00.
REQ-026 While rst is high, bus outputs SHALL be inactive: ALE = 0, RD = 1, WR = 1, CS = 4'hF, Data = high-impedance, Address = 20'h0.
REQ-027 Reset mid-cycle SHALL abort the cycle without issuing done.

Structure
REQ-028 A shared package SHALL hold the state enum, the CS index constants and the decode constants (8'hFF, 6'b000111).
REQ-029 Decode SHALL be a combinational sub-module named bus_addr_decode (inputs mio, addr; outputs cs_n[3:0], unmapped).

Verification
REQ-030 Read, req[0], mio=1, addr=20'h80010, memory byte 8'h5A: ALE only in T1, CS=4'b1110 in T1–T3, RD low in T2–T3, done[0] in cycle 4, rdata=8'h5A.
REQ-031 Write, req[1], mio=0, addr=20'h0FF04, wdata=8'hC3: CS=4'b1011, WR low and Data=8'hC3 in T2–T3; a following read of the same address returns 8'hC3.
REQ-032 Both req high from reset: grant order 0,1,0,1 with no idle gap between cycles; each done coincides with its gnt.
REQ-033 Unmapped I/O, addr=20'h01234: CS stays 4'hF, done and err pulse together, rdata=8'hFF.
REQ-034 rst asserted during T2 of a write: all outputs take reset values immediately, with no done and no device write.
REQ-035 req_addr changed in T2: Address keeps the value latched on entry to T1.
